// File: rtl/core_pkg.sv
// Shared core types: the dispatch uop carried from Dispatch into the issue queues.
package CORE_PKG;
    localparam int TAG_W = 7;

    typedef struct packed {
        logic [TAG_W-1:0] prs1;
        logic             prs1_rdy;
        logic [TAG_W-1:0] prs2;
        logic             prs2_rdy;
        logic [TAG_W-1:0] prd;
    } DispUOP;
endpackage

// File: rtl/wakeup_select_queue_if.sv
// Dispatch and issue bus of the wakeup/select queue; master is Dispatch, slave is the queue.
interface wakeup_select_queue_if #(
    parameter int NUM_FUS  = 4,
    parameter int NUM_COLS = 4
);
    localparam int IDX_W = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    logic                              disp_valid;
    CORE_PKG::DispUOP                  disp_uop;
    logic [IDX_W-1:0]                  payload_ram_index;
    logic [NUM_FUS-1:0]                disp_full;
    logic                              flush;
    logic [NUM_FUS-1:0]                iss_valid;
    CORE_PKG::DispUOP [NUM_FUS-1:0]    iss_uop;
    logic [NUM_FUS-1:0][COL_W-1:0]     iss_col;

    modport master (
        output disp_valid, disp_uop, payload_ram_index, flush,
        input  disp_full, iss_valid, iss_uop, iss_col
    );

    modport slave (
        input  disp_valid, disp_uop, payload_ram_index, flush,
        output disp_full, iss_valid, iss_uop, iss_col
    );
endinterface

// File: rtl/wakeup_select_queue.sv
// Per-FU issue queue rows with tag wakeup, one select per row and a registered issue stage.
// Define SELECT_OLDEST_EN to select the oldest ready entry instead of the lowest column.
module wakeup_select_queue #(
    parameter int NUM_FUS  = 4,
    parameter int NUM_COLS = 4,
    parameter int TAG_W    = CORE_PKG::TAG_W
) (
    input logic                  clk,
    input logic                  rst,
    wakeup_select_queue_if.slave bus
);
    import CORE_PKG::DispUOP;

    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    typedef enum logic [1:0] {
        E_FREE = 2'd0,
        E_WAIT = 2'd1,
        E_RDY  = 2'd2
    } entry_state_t;

    entry_state_t                  state_r   [NUM_FUS][NUM_COLS];
    entry_state_t                  state_s   [NUM_FUS][NUM_COLS];
    DispUOP                        payload_r [NUM_FUS][NUM_COLS];
    DispUOP                        payload_s [NUM_FUS][NUM_COLS];

    logic [NUM_FUS-1:0]            sel_found_s;
    logic [NUM_FUS-1:0][COL_W-1:0] sel_col_s;
    logic [NUM_FUS-1:0][TAG_W-1:0] bcast_tag_s;
    logic [NUM_FUS-1:0]            full_s;
    logic                          accept_s;
    logic [COL_W-1:0]              disp_col_s;
    DispUOP                        disp_wr_s;

    logic [NUM_FUS-1:0]            iss_valid_r;
    DispUOP [NUM_FUS-1:0]          iss_uop_r;
    logic [NUM_FUS-1:0][COL_W-1:0] iss_col_r;
    logic [NUM_FUS-1:0]            disp_full_r;

`ifdef SELECT_OLDEST_EN
    localparam int AGE_W = COL_W + 1;

    logic [AGE_W-1:0] age_r     [NUM_FUS][NUM_COLS];
    logic [AGE_W-1:0] age_cnt_r [NUM_FUS];

    // Wrap-aware: a is older than b when b is ahead of a by less than half the stamp range.
    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] d;
        d = b - a;
        return (d != {AGE_W{1'b0}}) && !d[AGE_W-1];
    endfunction
`endif

    function automatic logic tag_hit(input logic [TAG_W-1:0]              tag,
                                     input logic [NUM_FUS-1:0]            vld,
                                     input logic [NUM_FUS-1:0][TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FUS; i++) begin
            hit = hit | (vld[i] & (tags[i] == tag));
        end
        return hit;
    endfunction

    assign bus.iss_valid = iss_valid_r;
    assign bus.iss_uop   = iss_uop_r;
    assign bus.iss_col   = iss_col_r;
    assign bus.disp_full = disp_full_r;

    // Per-row select among RDY entries; the selected prd is that row's wakeup broadcast.
    always_comb begin
        sel_found_s = '0;
        sel_col_s   = '0;
        bcast_tag_s = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (state_r[f][c] == E_RDY) begin
`ifdef SELECT_OLDEST_EN
                    if (!sel_found_s[f] || older(age_r[f][c], age_r[f][sel_col_s[f]])) begin
`else
                    if (!sel_found_s[f]) begin
`endif
                        sel_found_s[f] = 1'b1;
                        sel_col_s[f]   = COL_W'(c);
                    end else begin
                        sel_col_s[f]   = sel_col_s[f];
                    end
                end else begin
                    sel_col_s[f] = sel_col_s[f];
                end
            end
            bcast_tag_s[f] = payload_r[f][sel_col_s[f]].prd;
        end
    end

    // Dispatch target and bypassed write data; a column freed this cycle is not reused yet.
    always_comb begin
        disp_col_s = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (state_r[bus.payload_ram_index][c] == E_FREE) begin
                disp_col_s = COL_W'(c);
            end else begin
                disp_col_s = disp_col_s;
            end
        end
        accept_s           = bus.disp_valid & ~disp_full_r[bus.payload_ram_index];
        disp_wr_s          = bus.disp_uop;
        disp_wr_s.prs1_rdy = bus.disp_uop.prs1_rdy |
                             tag_hit(bus.disp_uop.prs1, sel_found_s, bcast_tag_s);
        disp_wr_s.prs2_rdy = bus.disp_uop.prs2_rdy |
                             tag_hit(bus.disp_uop.prs2, sel_found_s, bcast_tag_s);
    end

    // Entry next state: selected entries free, waiting sources wake, dispatch writes.
    always_comb begin
        state_s   = state_r;
        payload_s = payload_r;
        full_s    = '1;
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                case (state_r[f][c])
                    E_RDY: begin
                        if (sel_found_s[f] && (sel_col_s[f] == COL_W'(c))) begin
                            state_s[f][c] = E_FREE;
                        end else begin
                            state_s[f][c] = E_RDY;
                        end
                    end
                    E_WAIT: begin
                        payload_s[f][c].prs1_rdy = payload_r[f][c].prs1_rdy |
                            tag_hit(payload_r[f][c].prs1, sel_found_s, bcast_tag_s);
                        payload_s[f][c].prs2_rdy = payload_r[f][c].prs2_rdy |
                            tag_hit(payload_r[f][c].prs2, sel_found_s, bcast_tag_s);
                        state_s[f][c] = (payload_s[f][c].prs1_rdy && payload_s[f][c].prs2_rdy)
                                        ? E_RDY : E_WAIT;
                    end
                    E_FREE:  state_s[f][c] = E_FREE;
                    default: state_s[f][c] = E_FREE;
                endcase
            end
        end
        if (accept_s) begin
            payload_s[bus.payload_ram_index][disp_col_s] = disp_wr_s;
            state_s[bus.payload_ram_index][disp_col_s]   =
                (disp_wr_s.prs1_rdy && disp_wr_s.prs2_rdy) ? E_RDY : E_WAIT;
        end else begin
            state_s[bus.payload_ram_index][disp_col_s] = state_s[bus.payload_ram_index][disp_col_s];
        end
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                full_s[f] = full_s[f] & (state_s[f][c] != E_FREE);
            end
        end
    end

    // Entry state and issue/full registers; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int f = 0; f < NUM_FUS; f++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    state_r[f][c] <= E_FREE;
                end
            end
            iss_valid_r <= '0;
            iss_uop_r   <= '0;
            iss_col_r   <= '0;
            disp_full_r <= '0;
        end else begin
            state_r     <= state_s;
            iss_valid_r <= sel_found_s;
            for (int f = 0; f < NUM_FUS; f++) begin
                iss_uop_r[f] <= sel_found_s[f] ? payload_r[f][sel_col_s[f]] : '0;
            end
            iss_col_r   <= sel_col_s;
            disp_full_r <= full_s;
        end
    end

    // Payload storage is only meaningful under a non-FREE state, so it carries no reset.
    always_ff @(posedge clk) begin
        payload_r <= payload_s;
    end

`ifdef SELECT_OLDEST_EN
    // Stamp each accepted dispatch from its row's wrapping counter.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int f = 0; f < NUM_FUS; f++) begin
                age_cnt_r[f] <= '0;
                for (int c = 0; c < NUM_COLS; c++) begin
                    age_r[f][c] <= '0;
                end
            end
        end else if (accept_s) begin
            age_r[bus.payload_ram_index][disp_col_s] <= age_cnt_r[bus.payload_ram_index];
            age_cnt_r[bus.payload_ram_index] <= age_cnt_r[bus.payload_ram_index] + AGE_W'(1);
        end else begin
            age_cnt_r <= age_cnt_r;
        end
    end
`endif

endmodule
